// File: rtl/lsu_pkg.sv
// Shared access-size encodings and FSM state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RD,
    RESP
  } lsu_state_t;

  // Stores only have signed-size encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus bundled for the load/store unit.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  // Handshakes: a transfer happens on a rising edge where valid && ready (or
  // req && gnt) are both high; the initiator holds valid/req and its payload
  // stable until that edge, and the responder may not make ready depend on
  // anything later than the current cycle. mem_rvalid is a one-cycle strobe.
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // master is the load/store unit; slave is the pipeline plus data memory around it.
  modport master (
    input  req_valid, MemRead, MemWrite, Funct3, addr, wd, rsp_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, MemRead, MemWrite, Funct3, addr, wd, rsp_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and
// extension, plus illegal-size and misalignment detection.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic              store,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned,
  output logic              illegal
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    illegal = !f3_legal(funct3, store);

    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = (offset != 2'b00);
      default: misaligned = 1'b0;
    endcase

    be    = 4'b0000;
    wdata = '0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{wd[7:0]}};
      end
      F3_H: begin
        be    = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{wd[15:0]}};
      end
      F3_W: begin
        be    = 4'b1111;
        wdata = wd;
      end
      default: begin
        be    = 4'b0000;
        wdata = '0;
      end
    endcase
    if (!store) be = 4'b0000;

    // Word loads are only legal at offset 0, so the shifted word is the raw word.
    shifted   = rdata >> {offset, 3'b000};
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator between the execute stage and data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  load_store_unit_if.master   bus,
  output lsu_state_t          debug_state
);

  lsu_state_t            state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic                  in_idle;
  logic                  new_store;
  logic                  no_op;
  logic [2:0]            al_f3;
  logic [1:0]            al_off;
  logic                  al_store;
  logic [3:0]            al_be;
  logic [DATA_W-1:0]     al_wdata;
  logic [DATA_W-1:0]     al_load;
  logic                  al_misaligned;
  logic                  al_illegal;
  logic                  unused_addr_bits;

  assign in_idle   = (state_q == IDLE);
  assign new_store = !bus.MemRead && bus.MemWrite;
  assign no_op     = !bus.MemRead && !bus.MemWrite;

  // Decode the live request while idle; afterwards extract from the captured fields.
  assign al_f3    = in_idle ? bus.Funct3    : f3_q;
  assign al_off   = in_idle ? bus.addr[1:0] : off_q;
  assign al_store = in_idle ? new_store     : store_q;

  assign unused_addr_bits = ^bus.addr[31:DM_ADDRESS];

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (al_f3),
    .offset     (al_off),
    .store      (al_store),
    .wd         (bus.wd),
    .rdata      (bus.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d = new_store;
          f3_d    = bus.Funct3;
          off_d   = bus.addr[1:0];
          if (no_op || al_illegal || al_misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = new_store;
            mem_addr_d  = {bus.addr[DM_ADDRESS-1:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = new_store ? al_wdata : '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (store_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else if (bus.mem_rvalid) begin
            // Zero-latency memory returns data alongside the grant.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = al_load;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (bus.mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = al_load;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign debug_state   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized transactions against the load/store unit with a response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [32:0] exp_q[$];
  lsu_state_t debug_state;

  load_store_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .debug_state (debug_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic model_err(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic legal;
    if (rd)      legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (wr) legal = f3 inside {3'b000, 3'b001, 3'b010};
    else         legal = 1'b0;
    if (legal && f3[1:0] == 2'b01 && a[0])      legal = 1'b0;
    if (legal && f3[1:0] == 2'b10 && a != 2'b00) legal = 1'b0;
    return !legal;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return r;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000: case (a)
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {w[7:0], w[7:0], w[7:0], w[7:0]};
      3'b001:  return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  // driver: one full transaction with g grant-stall cycles, rvalid rv cycles
  // after grant, and rsp_ready held low for rdy cycles
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int g, input int rv, input int rdy);
    logic        err;
    logic        store;
    logic [31:0] exp_data;
    logic [32:0] exp;
    int          acc;
    int          to;
    int          exp_lat;
    err      = model_err(rd, wr, f3, a[1:0]);
    store    = !rd;
    exp_data = (err || store) ? 32'h0 : model_load(f3, a[1:0], rdat);
    exp_lat  = err ? 0 : (store ? 1 + g : 1 + g + rv);
    exp_q.push_back({err, exp_data});

    check({tag, "/req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Funct3    = f3;
    bus.addr      = a;
    bus.wd        = wd;
    bus.mem_rdata = ~rdat;
    tick();
    bus.req_valid = 1'b0;
    bus.wd        = ~wd;
    acc = cyc;

    if (err) begin
      check({tag, "/no_mem_req"}, 32'(bus.mem_req), 32'd0);
    end else begin
      for (int i = 0; i <= g; i++) begin
        check({tag, "/mem_req"}, 32'(bus.mem_req), 32'd1);
        check({tag, "/mem_we"}, 32'(bus.mem_we), 32'(store));
        check({tag, "/mem_addr"}, 32'(bus.mem_addr), 32'(a[8:0] & 9'h1FC));
        check({tag, "/mem_be"}, 32'(bus.mem_be), store ? 32'(model_be(f3, a[1:0])) : 32'd0);
        if (store) check({tag, "/mem_wdata"}, bus.mem_wdata, model_wdata(f3, wd));
        check({tag, "/req_ready_busy"}, 32'(bus.req_ready), 32'd0);
        if (i == g) begin
          bus.mem_gnt = 1'b1;
          if (!store && rv == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdat;
          end
        end
        tick();
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = ~rdat;
      check({tag, "/mem_req_drop"}, 32'(bus.mem_req), 32'd0);
      if (!store && rv > 0) begin
        for (int i = 1; i < rv; i++) begin
          check({tag, "/wait_rd"}, 32'(debug_state), 32'(WAIT_RD));
          check({tag, "/req_ready_wait"}, 32'(bus.req_ready), 32'd0);
          tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdat;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = ~rdat;
      end
    end

    to = 0;
    while (!bus.rsp_valid && to < 20) begin
      tick();
      to++;
    end
    check({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "/latency"}, 32'(cyc - acc), 32'(exp_lat));
    for (int i = 0; i < rdy; i++) begin
      check({tag, "/rsp_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "/rsp_hold_data"}, bus.rsp_rdata, exp_data);
      check({tag, "/req_ready_resp"}, 32'(bus.req_ready), 32'd0);
      tick();
    end
    // scoreboard: pop at the response handshake
    bus.rsp_ready = 1'b1;
    exp = exp_q.pop_front();
    check({tag, "/rsp_rdata"}, bus.rsp_rdata, exp[31:0]);
    check({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'(exp[32]));
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, "/rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "/req_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Funct3     = 3'b000;
    bus.addr       = 32'h0;
    bus.wd         = 32'h0;
    bus.rsp_ready  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    tick();
    tick();
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst/mem_req", 32'(bus.mem_req), 32'd0);
    check("rst/mem_we", 32'(bus.mem_we), 32'd0);
    check("rst/mem_be", 32'(bus.mem_be), 32'd0);
    check("rst/mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst/mem_wdata", bus.mem_wdata, 32'd0);
    check("rst/state", 32'(debug_state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // directed accesses: tag, rd, wr, f3, addr, wd, rdata, gnt/rvalid/ready delays
    run_op("sb_103",  1'b0, 1'b1, F3_B,  32'h0000_0103, 32'hAABBCCDD, 32'h0, 0, 0, 0);
    run_op("lb_102",  1'b1, 1'b0, F3_B,  32'h0000_0102, 32'h0, 32'h1280_3456, 0, 0, 0);
    run_op("lbu_102", 1'b1, 1'b0, F3_BU, 32'h0000_0102, 32'h0, 32'h1280_3456, 0, 0, 0);
    run_op("lh_102",  1'b1, 1'b0, F3_H,  32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 0, 0);
    run_op("lhu_102", 1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 0, 0);
    run_op("lw_104",  1'b1, 1'b0, F3_W,  32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    run_op("lw_102",  1'b1, 1'b0, F3_W,  32'h0000_0102, 32'h0, 32'h1234_5678, 0, 0, 0);
    run_op("sh_101",  1'b0, 1'b1, F3_H,  32'h0000_0101, 32'h1111_2222, 32'h0, 0, 0, 0);
    run_op("ld_f3_3", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h5555_5555, 0, 0, 0);
    run_op("st_f3_4", 1'b0, 1'b1, F3_BU, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 0);
    run_op("no_op",   1'b0, 1'b0, F3_W,  32'h0000_0100, 32'h0, 32'h0, 0, 0, 0);
    run_op("both_lb", 1'b1, 1'b1, F3_B,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_7F00, 0, 0, 0);
    run_op("lh_stall", 1'b1, 1'b0, F3_H, 32'h0000_0100, 32'h0, 32'h0000_F00D, 3, 2, 2);
    run_op("sh_106",  1'b0, 1'b1, F3_H,  32'h0000_0106, 32'hCAFE_BABE, 32'h0, 1, 0, 2);
    run_op("sw_1fc",  1'b0, 1'b1, F3_W,  32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0, 2, 0, 1);

    // reset while waiting for a grant
    bus.req_valid = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b1;
    bus.Funct3 = F3_W; bus.addr = 32'h0000_0010; bus.wd = 32'h1234_5678;
    tick();
    bus.req_valid = 1'b0;
    check("rst_req/mem_req_before", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_req/mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_req/req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    reset = 1'b0;

    // reset while waiting for read data; a late rvalid must be ignored
    bus.req_valid = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
    bus.Funct3 = F3_W; bus.addr = 32'h0000_0020;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("rst_wait/state", 32'(debug_state), 32'(WAIT_RD));
    #2 reset = 1'b1;
    #1;
    check("rst_wait/mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_wait/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_wait/req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    check("late_rvalid/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("late_rvalid/state", 32'(debug_state), 32'(IDLE));
    run_op("after_rst", 1'b1, 1'b0, F3_HU, 32'h0000_0022, 32'h0, 32'h9ABC_0000, 1, 1, 1);

    // randomized accesses, including illegal and misaligned ones
    for (int k = 0; k < 12; k++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    check("sb/queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
